// File: rtl/dcache_direct_mapped.sv
// ----------------------------------------------------------------------------
// dcache_direct_mapped
//
// Direct-mapped, write-back, write-allocate data cache between the pipeline's
// MEM stage (CPU side) and a block-wide main memory port.
//
// Optional feature: define DCACHE_STATS_EN to add the hit_cnt / miss_cnt
// saturating statistics outputs.
//
// Ports:
//   clk         in   1    rising-edge clock
//   rst_n       in   1    synchronous active-low reset
//   proc_read   in   1    CPU read request
//   proc_write  in   1    CPU write request (wins over proc_read)
//   proc_addr   in   30   CPU word address {tag, index, word}
//   proc_wdata  in   32   CPU write data
//   proc_stall  out  1    request not yet complete; CPU freezes
//   proc_rdata  out  32   read data, valid on a read with proc_stall low
//   mem_read    out  1    memory block read request
//   mem_write   out  1    memory block write request
//   mem_addr    out  28   memory block address
//   mem_wdata   out  128  block written back
//   mem_ready   in   1    memory finished current request (1-cycle pulse)
//   mem_rdata   in   128  fill block, valid with mem_ready
//   hit_cnt     out  32   (DCACHE_STATS_EN) COMPARE cycles that hit
//   miss_cnt    out  32   (DCACHE_STATS_EN) misses detected
//   state_dbg   out  2    current FSM state (0 COMPARE, 1 WRITEBACK, 2 ALLOCATE)
//
// Handshake: mem_read / mem_write are held high, with mem_addr / mem_wdata
// stable, until mem_ready is sampled high on a rising edge; that edge ends
// the request. mem_ready seen while neither request is high is ignored. The
// CPU side holds proc_* stable for as long as proc_stall is high.
// ----------------------------------------------------------------------------
module dcache_direct_mapped #(
    parameter  int NUM_BLOCKS = 8,
    localparam int IDX_W      = $clog2(NUM_BLOCKS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          proc_read,
    input  logic          proc_write,
    input  logic [29:0]   proc_addr,
    input  logic [31:0]   proc_wdata,
    output logic          proc_stall,
    output logic [31:0]   proc_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [27:0]   mem_addr,
    output logic [127:0]  mem_wdata,
    input  logic          mem_ready,
    input  logic [127:0]  mem_rdata,
`ifdef DCACHE_STATS_EN
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt,
`endif
    output logic [1:0]    state_dbg
);

    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        S_COMPARE   = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [127:0]          data_q [NUM_BLOCKS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       word_sel;
    logic [127:0]     line;
    logic             req;
    logic             hit;
    logic             miss_evt;
    logic             wb_done;
    logic             fill_done;

    assign idx      = proc_addr[IDX_W+1:2];
    assign tag      = proc_addr[29:IDX_W+2];
    assign word_sel = proc_addr[1:0];
    assign line     = data_q[idx];
    assign req      = proc_read | proc_write;
    assign hit      = (state_q == S_COMPARE) & req & valid_q[idx] & (tag_q[idx] == tag);

    assign wb_done   = (state_q == S_WRITEBACK) & mem_ready;
    assign fill_done = (state_q == S_ALLOCATE) & mem_ready;

    assign state_dbg = state_q;

    // Next state and all outputs. Memory-side outputs are pure functions of
    // the state, so a reset drops them the cycle after it is sampled.
    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        proc_rdata = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 28'd0;
        mem_wdata  = 128'd0;
        miss_evt   = 1'b0;
        case (state_q)
            S_COMPARE: begin
                if (req) begin
                    if (hit) begin
                        // Simultaneous read+write is a write: no read data.
                        if (!proc_write) begin
                            proc_rdata = line[{word_sel, 5'b0} +: 32];
                        end
                    end else begin
                        proc_stall = 1'b1;
                        miss_evt   = 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_d = S_WRITEBACK;
                        end else begin
                            state_d = S_ALLOCATE;
                        end
                    end
                end
            end
            S_WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[idx], idx};
                mem_wdata  = line;
                if (mem_ready) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[29:2];
                if (mem_ready) begin
                    state_d = S_COMPARE;
                end
            end
            default: begin
                state_d = S_COMPARE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_COMPARE;
        end else begin
            state_q <= state_d;
        end
    end

    // Line status bits are the only per-line state that needs a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (hit && proc_write) begin
                dirty_q[idx] <= 1'b1;
            end
            if (wb_done) begin
                dirty_q[idx] <= 1'b0;
            end
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (hit && proc_write) begin
                data_q[idx][{word_sel, 5'b0} +: 32] <= proc_wdata;
            end
            if (fill_done) begin
                data_q[idx] <= mem_rdata;
                tag_q[idx]  <= tag;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (hit && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            // miss_evt is only high in COMPARE, so this counts the
            // COMPARE->WRITEBACK/ALLOCATE edge once per miss.
            if (miss_evt && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// ----------------------------------------------------------------------------
// tb_dcache_direct_mapped
//
// Self-checking bench for dcache_direct_mapped. Expected values come from a
// behavioural model: a flat word-level view of what the CPU should read, a
// backing memory of blocks, and a per-index record of which block is resident
// and whether it holds unwritten data. Directed steps follow the cache's key
// scenarios, then randomized accesses over a small address range.
// ----------------------------------------------------------------------------
module tb_dcache_direct_mapped;

    localparam int NB = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          proc_read;
    logic          proc_write;
    logic [29:0]   proc_addr;
    logic [31:0]   proc_wdata;
    logic          proc_stall;
    logic [31:0]   proc_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic          mem_ready;
    logic [127:0]  mem_rdata;
    logic [1:0]    state_dbg;
`ifdef DCACHE_STATS_EN
    logic [31:0]   hit_cnt;
    logic [31:0]   miss_cnt;
`endif

    dcache_direct_mapped #(.NUM_BLOCKS(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
`ifdef DCACHE_STATS_EN
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid [NB];
    bit          m_dirty [NB];
    logic [27:0] m_blk   [NB];
    int          exp_hits = 0;
    int          exp_miss = 0;

    logic [127:0] dram  [logic [27:0]];   // backing memory, blocks
    logic [31:0]  truth [logic [29:0]];   // CPU-visible words written so far

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [127:0] dram_block(input logic [27:0] blk);
        logic [127:0] r;
        if (dram.exists(blk)) return dram[blk];
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = init_word({blk, 2'(k)});
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input logic [29:0] a);
        logic [127:0] b;
        if (truth.exists(a)) return truth[a];
        b = dram_block(a[29:2]);
        return b[{a[1:0], 5'b0} +: 32];
    endfunction

    function automatic logic [127:0] exp_block(input logic [27:0] blk);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = exp_word({blk, 2'(k)});
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_blk[i]   = '0;
        end
        // Dirty data held only in the cache is lost; memory is the truth.
        truth.delete();
        exp_hits = 0;
        exp_miss = 0;
    endfunction

    // ---------------- driver tasks ----------------
    // mode: 0 read, 1 write, 2 read+write (acts as a write)
    task automatic do_access(input int mode, input logic [29:0] a, input logic [31:0] d,
                             input int lat_wb, input int lat_al);
        logic [27:0] blk;
        logic [27:0] ev_blk;
        int          idx;
        bit          hit;
        bit          ev;
        bit          is_wr;
        bit          done;
        int          stall_c;
        int          wb_c;
        int          al_c;
        int          exp_stall;
        blk     = a[29:2];
        idx     = int'(a[4:2]);
        hit     = m_valid[idx] && (m_blk[idx] == blk);
        ev      = !hit && m_valid[idx] && m_dirty[idx];
        ev_blk  = m_blk[idx];
        is_wr   = (mode != 0);
        done    = 1'b0;
        stall_c = 0;
        wb_c    = 0;
        al_c    = 0;
        exp_stall = hit ? 0 : (1 + (ev ? lat_wb : 0) + lat_al);

        @(negedge clk);
        proc_read  = (mode != 1);
        proc_write = (mode != 0);
        proc_addr  = a;
        proc_wdata = d;
        #1;
        while (!done && stall_c < 200) begin
            if (!proc_stall) begin
                done = 1'b1;
            end else begin
                stall_c++;
                check("mem_excl", 128'(mem_read & mem_write), 128'd0);
                if (mem_write) begin
                    wb_c++;
                    if (wb_c == 1) begin
                        check("wb_addr", 128'(mem_addr), 128'(ev_blk));
                        check("wb_data", mem_wdata, exp_block(ev_blk));
                    end
                    if (wb_c == lat_wb) begin
                        dram[ev_blk] = exp_block(ev_blk);
                        mem_ready = 1'b1;
                    end
                end else if (mem_read) begin
                    al_c++;
                    if (al_c == 1) check("al_addr", 128'(mem_addr), 128'(blk));
                    if (al_c == lat_al) begin
                        mem_rdata = dram_block(blk);
                        mem_ready = 1'b1;
                    end
                end
                @(negedge clk);
                mem_ready = 1'b0;
                mem_rdata = '0;
                #1;
            end
        end
        check("completed", 128'(done), 128'd1);
        check("stall_cycles", 128'(stall_c), 128'(exp_stall));
        check("wb_cycles", 128'(wb_c), 128'(ev ? lat_wb : 0));
        check("idle_mem_read", 128'(mem_read), 128'd0);
        check("idle_mem_write", 128'(mem_write), 128'd0);
        if (mode == 0) check("rdata", 128'(proc_rdata), 128'(exp_word(a)));

        if (!hit) begin
            exp_miss++;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_blk[idx]   = blk;
        end
        exp_hits++;
        if (is_wr) begin
            m_dirty[idx] = 1'b1;
            truth[a]     = d;
        end

        @(posedge clk);
        #1;
`ifdef DCACHE_STATS_EN
        check("hit_cnt", 128'(hit_cnt), 128'(exp_hits));
        check("miss_cnt", 128'(miss_cnt), 128'(exp_miss));
`endif
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int seen;
        int k;
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        model_reset();
        dram[28'h4] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_stall", 128'(proc_stall), 128'd0);
        check("rst_mem_read", 128'(mem_read), 128'd0);
        check("rst_mem_write", 128'(mem_write), 128'd0);
        check("rst_mem_addr", 128'(mem_addr), 128'd0);
        check("rst_mem_wdata", mem_wdata, 128'd0);
        check("rst_rdata", 128'(proc_rdata), 128'd0);
        check("rst_state", 128'(state_dbg), 128'd0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_cnt", 128'(hit_cnt), 128'd0);
        check("rst_miss_cnt", 128'(miss_cnt), 128'd0);
`endif

        // Cold read miss, 3-cycle memory, then same-line read hit.
        do_access(0, 30'h10, 32'd0, 1, 3);
        do_access(0, 30'h11, 32'd0, 1, 1);

        // Stray mem_ready with no outstanding request must be ignored.
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        check("stray_stall", 128'(proc_stall), 128'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '0;
        #1;
        check("stray_state", 128'(state_dbg), 128'd0);
        do_access(0, 30'h11, 32'd0, 1, 1);

        // Write hit, then conflicting read forces a writeback of the line.
        do_access(1, 30'h10, 32'h1234_5678, 2, 2);
        do_access(0, 30'h30, 32'd0, 3, 2);
        do_access(0, 30'h10, 32'd0, 1, 2);

        // Long memory latency.
        do_access(0, 30'h2C, 32'd0, 1, 10);

        // Reset while ALLOCATE is outstanding.
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h48;
        #1;
        seen = 0;
        k    = 0;
        while (seen < 2 && k < 20) begin
            if (mem_read) seen++;
            @(negedge clk);
            #1;
            k++;
        end
        check("rst_mid_reached_alloc", 128'(seen), 128'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_mem_read", 128'(mem_read), 128'd0);
        check("rst_mid_mem_write", 128'(mem_write), 128'd0);
        check("rst_mid_state", 128'(state_dbg), 128'd0);
        proc_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_access(0, 30'h48, 32'd0, 1, 2);

        // One miss followed by further hits on the same line.
        do_access(0, 30'h60, 32'd0, 1, 2);
        do_access(0, 30'h61, 32'd0, 1, 1);
        do_access(0, 30'h62, 32'd0, 1, 1);

        // Randomized traffic: 4 tags per index so conflicts are frequent.
        for (int i = 0; i < 200; i++) begin
            do_access(int'($urandom_range(0, 2)), 30'($urandom_range(0, 127)), $urandom,
                      int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        end

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
